// File: rtl/dac_ramp_if.sv
// Handshake bundle between the ramp sequencer and its target source / DAC serializer.
interface dac_ramp_if;
  logic [11:0] tgt_code;
  logic        tgt_valid;
  logic        tgt_ready;
  logic [11:0] step;
  logic [11:0] dac_data;
  logic        dac_valid;
  logic        dac_ready;
  logic        busy;
  logic        at_target;
  logic        clamp_flag;

  modport slave (
    input  tgt_code, tgt_valid, step, dac_ready,
    output tgt_ready, dac_data, dac_valid, busy, at_target, clamp_flag
  );

  modport master (
    output tgt_code, tgt_valid, step, dac_ready,
    input  tgt_ready, dac_data, dac_valid, busy, at_target, clamp_flag
  );
endinterface

// File: rtl/dac_ramp_ctrl.sv
// Slew-limited DAC setpoint sequencer: clamps targets, steps toward them, offers each code
// over valid/ready; an offer is held stable until accepted, then the block waits INTERVAL cycles.
module dac_ramp_ctrl #(
  parameter logic [11:0] CODE_INIT = 12'd1790,
  parameter logic [11:0] CODE_MIN  = 12'd1310,
  parameter logic [11:0] CODE_MAX  = 12'd1720,
  parameter logic [15:0] INTERVAL  = 16'd5000
) (
  input  logic       clk,
  input  logic       rst,
  dac_ramp_if.slave  bus
);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_STEP,
    S_ISSUE,
    S_HOLD
  } state_e;

  state_e      state_q, state_d;
  logic [11:0] cur_q, cur_d;
  logic [11:0] tgt_q, tgt_d;
  logic [11:0] dat_q, dat_d;
  logic [15:0] cnt_q, cnt_d;
  logic        vld_q, vld_d;
  logic        at_q, at_d;
  logic        clamp_q, clamp_d;

  logic               hs;
  logic signed [12:0] diff;
  logic [12:0]        diff_abs;
  logic [11:0]        step_eff;
  logic [11:0]        mag;
  logic [11:0]        nxt;

  assign hs = vld_q && bus.dac_ready;

  // 13-bit signed difference keeps the full 0..4095 range without wrapping.
  always_comb begin
    diff     = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
    diff_abs = diff[12] ? 13'(-diff) : 13'(diff);
    step_eff = (bus.step == 12'd0) ? 12'd1 : bus.step;
    mag      = ({1'b0, step_eff} < diff_abs) ? step_eff : diff_abs[11:0];
    nxt      = diff[12] ? (cur_q - mag) : (cur_q + mag);
  end

  always_comb begin
    state_d = state_q;
    cur_d   = cur_q;
    tgt_d   = tgt_q;
    dat_d   = dat_q;
    cnt_d   = cnt_q;
    clamp_d = clamp_q;

    if (bus.tgt_valid) begin
      if (bus.tgt_code > CODE_MAX) begin
        tgt_d   = CODE_MAX;
        clamp_d = 1'b1;
      end else if (bus.tgt_code < CODE_MIN) begin
        tgt_d   = CODE_MIN;
        clamp_d = 1'b1;
      end else begin
        tgt_d   = bus.tgt_code;
        clamp_d = 1'b0;
      end
    end

    case (state_q)
      S_INIT: begin
        if (hs) begin
          cur_d   = CODE_INIT;
          cnt_d   = 16'd0;
          state_d = S_HOLD;
        end
      end
      S_IDLE: begin
        if (tgt_q != cur_q) state_d = S_STEP;
      end
      S_STEP: begin
        // A target rewritten back to cur during IDLE needs no write.
        if (nxt != cur_q) begin
          dat_d   = nxt;
          state_d = S_ISSUE;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_ISSUE: begin
        if (hs) begin
          cur_d   = dat_q;
          cnt_d   = 16'd0;
          state_d = S_HOLD;
        end
      end
      S_HOLD: begin
        if (cnt_q == INTERVAL) state_d = S_IDLE;
        else                   cnt_d   = cnt_q + 16'd1;
      end
      default: state_d = S_INIT;
    endcase

    vld_d = (state_d == S_INIT) || (state_d == S_ISSUE);
    at_d  = (state_q == S_IDLE) && (tgt_q == cur_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      cur_q   <= CODE_INIT;
      tgt_q   <= CODE_INIT;
      dat_q   <= CODE_INIT;
      cnt_q   <= 16'd0;
      vld_q   <= 1'b0;
      at_q    <= 1'b0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cur_q   <= cur_d;
      tgt_q   <= tgt_d;
      dat_q   <= dat_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      at_q    <= at_d;
      clamp_q <= clamp_d;
    end
  end

  assign bus.tgt_ready  = 1'b1;
  assign bus.dac_data   = dat_q;
  assign bus.dac_valid  = vld_q;
  assign bus.busy       = (state_q != S_IDLE);
  assign bus.at_target  = at_q;
  assign bus.clamp_flag = clamp_q;

endmodule

// File: doc/dac_ramp_ctrl.md
# dac_ramp_ctrl

Setpoint sequencer directly upstream of the DAC7512 serial driver. Accepts 12-bit target codes, clamps them to a legal window, and moves the DAC output toward the target in slew-limited steps. Each intermediate code is handed to the serializer over a valid/ready handshake. This avoids output jumps on the laser/threshold bias rail and replaces the fixed power-up code with a controlled, programmable one.

## Interface

Parameters:
- CODE_INIT, 12'd1790, code written once after reset and held as initial current code
- CODE_MIN, 12'd1310, lowest legal code (about 1.6 V)
- CODE_MAX, 12'd1720, highest legal code (about 2.1 V)
- INTERVAL, 16'd5000, clk cycles to wait after each accepted DAC write before the next step (0 = no wait)

Ports:
- clk  in  1  system clock, 50 MHz
- rst  in  1  reset; one clock; reset is synchronous and active-high
- tgt_code  in  12  requested target code
- tgt_valid  in  1  tgt_code qualifier
- tgt_ready  out  1  target accept; constant 1 out of reset
- step  in  12  maximum code change per write; sampled at each step computation; 0 treated as 1
- dac_data  out  12  code to serializer; stable while dac_valid=1
- dac_valid  out  1  dac_data offered
- dac_ready  in  1  serializer accepts dac_data (frame started)
- busy  out  1  high in any state other than IDLE
- at_target  out  1  current code equals latched target and state is IDLE
- clamp_flag  out  1  last accepted target was outside [CODE_MIN, CODE_MAX]

## Operation

- Registers: cur (last code acknowledged by serializer), tgt (latched, clamped target), nxt, wait counter (16 bit).
- Target accept: on any cycle with tgt_valid=1, tgt <= clamp(tgt_code) and clamp_flag <= out-of-window. A later accept overwrites an earlier one, including mid-ramp. The new tgt applies at the next STEP computation and does not disturb an in-flight offer.
- States:
  - INIT: entered from reset. Offers CODE_INIT with dac_valid=1. On dac_ready, cur <= CODE_INIT and go to HOLD.
  - IDLE: if tgt != cur, go to STEP; otherwise stay.
  - STEP: one cycle. Compute diff = tgt - cur as a 13-bit signed value, and s = max(step,1). nxt = cur + min(s,|diff|) if diff>0, else cur - min(s,|diff|). The result never overshoots and never wraps.
  - ISSUE: dac_data=nxt, dac_valid=1. Hold both until dac_ready=1. On the handshake cycle, cur <= nxt and go to HOLD.
  - HOLD: count INTERVAL cycles, then go to IDLE. With INTERVAL=0, go to IDLE the next cycle.
- dac_valid deasserts the cycle after the handshake. dac_data keeps its last value when not valid.
- Clamp: codes above CODE_MAX become CODE_MAX; codes below CODE_MIN become CODE_MIN. CODE_INIT is not clamped.
- Reset mid-operation: any state returns to the reset values below. The pending offer is dropped. INIT is re-entered and CODE_INIT is re-sent.

## Timing

- Reset values: tgt_ready=1, dac_data=CODE_INIT, dac_valid=0, busy=1, at_target=0, clamp_flag=0; tgt=CODE_INIT, cur=CODE_INIT, state INIT.
- The first cycle after rst falls has dac_valid=1 (INIT).
- Accept at edge N while IDLE (cur != new target):
  - tgt updates at N+1.
  - STEP runs at N+1 to N+2.
  - dac_valid=1 from edge N+2.
- Handshake at edge H: cur updates at H. HOLD spans INTERVAL cycles. The next dac_valid rises at H+INTERVAL+3.
- Simultaneous tgt_valid and STEP evaluation: STEP uses the pre-update tgt. The new value applies from the following STEP.
- at_target is registered. It updates one cycle after entering or leaving IDLE with tgt==cur.
- dac_ready while dac_valid=0 is ignored.

## Test plan

- Reset release with dac_ready tied 1 → one write of 1790, then busy=1 for INTERVAL cycles. Then IDLE with tgt=cur=1790 and at_target=1. No further writes.
- INTERVAL=0, step=100, target 1310 from 1790 → written sequence 1690, 1590, 1490, 1390, 1310. No undershoot. at_target=1 after the last write.
- Target 4095 → clamp_flag=1, ramp ends at 1720. Target 0 → ramp ends at 1310, clamp_flag stays 1. Target 1500 → clamp_flag=0.
- dac_ready held 0 for 40 cycles during ISSUE → dac_valid and dac_data stay constant. A new tgt_valid in that window does not change dac_data. The next STEP heads to the new target.
- step=0, target = cur+3 → three writes of +1 each.
- rst pulsed for 1 cycle during HOLD mid-ramp → dac_valid=0 in the reset cycle, then INIT re-sends 1790, and tgt is back to 1790.
